// File: rtl/cpu_pkg.sv
// Shared CPU encodings for the ALU write-back path: write-back source and
// destination selects, exception causes and the write-back FSM state type.
package cpu_pkg;

  localparam logic [2:0] WB_ALU   = 3'd0;
  localparam logic [2:0] WB_MDR   = 3'd1;
  localparam logic [2:0] WB_HI    = 3'd2;
  localparam logic [2:0] WB_LO    = 3'd3;
  localparam logic [2:0] WB_SHIFT = 3'd4;
  localparam logic [2:0] WB_PC    = 3'd5;
  localparam logic [2:0] WB_IMM   = 3'd6;
  localparam logic [2:0] WB_SLT   = 3'd7;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;
  localparam logic [1:0] DST_SP = 2'd3;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WRITE = 2'd2,
    ST_EXC   = 2'd3
  } wb_state_t;

endpackage

// File: rtl/alu_wb_stage_if.sv
// Bundle between the control unit/datapath (master) and the ALU write-back
// stage (slave): operand/select inputs plus register-bank and exception outputs.
interface alu_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [DATA_W-1:0] alu_result;
  logic              alu_overflow;
  logic              ovf_check;
  logic              wb_en;
  logic [2:0]        wb_sel;
  logic [1:0]        reg_dst;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] shift_out;
  logic [DATA_W-1:0] pc;
  logic [15:0]       imm16;

  logic [DATA_W-1:0] alu_out_reg;
  logic              zero_flag;
  logic              lt_flag;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              exc_req;
  logic [1:0]        exc_cause;
  logic              busy;

  modport master (
    output alu_valid, alu_result, alu_overflow, ovf_check, wb_en, wb_sel,
           reg_dst, rt, rd, mdr, hi, lo, shift_out, pc, imm16,
    input  alu_out_reg, zero_flag, lt_flag, rf_we, rf_waddr, rf_wdata,
           exc_req, exc_cause, busy
  );

  modport slave (
    input  alu_valid, alu_result, alu_overflow, ovf_check, wb_en, wb_sel,
           reg_dst, rt, rd, mdr, hi, lo, shift_out, pc, imm16,
    output alu_out_reg, zero_flag, lt_flag, rf_we, rf_waddr, rf_wdata,
           exc_req, exc_cause, busy
  );
endinterface

// File: rtl/wb_data_mux.sv
// Combinational write-back selection: 8:1 data source mux and 4:1
// destination register mux.
module wb_data_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [2:0]        wb_sel,
  input  logic [1:0]        reg_dst,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] mdr,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] shift_out,
  input  logic [DATA_W-1:0] pc,
  input  logic [15:0]       imm16,
  input  logic              slt_bit,
  output logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] waddr
);

  // Write-back data source
  always_comb begin
    wdata = {DATA_W{1'b0}};
    case (wb_sel)
      WB_ALU:   wdata = alu_out;
      WB_MDR:   wdata = mdr;
      WB_HI:    wdata = hi;
      WB_LO:    wdata = lo;
      WB_SHIFT: wdata = shift_out;
      WB_PC:    wdata = pc;
      WB_IMM:   wdata = {imm16, {(DATA_W-16){1'b0}}};
      WB_SLT:   wdata = {{(DATA_W-1){1'b0}}, slt_bit};
      default:  wdata = {DATA_W{1'b0}};
    endcase
  end

  // Destination register; $31 is the link register, $29 the stack pointer
  always_comb begin
    waddr = {ADDR_W{1'b0}};
    case (reg_dst)
      DST_RT:  waddr = rt;
      DST_RD:  waddr = rd;
      DST_RA:  waddr = ADDR_W'(5'd31);
      DST_SP:  waddr = ADDR_W'(5'd29);
      default: waddr = {ADDR_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU write-back stage: ALUOut/flag capture, overflow trap and register-bank
// write. Define WB_FAST_EN to skip the CHECK cycle and decide on the capture edge.
module alu_wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic    clk,
  input  logic    reset,
  alu_wb_if.slave bus
);

  wb_state_t         state_r;
  wb_state_t         state_next_s;
  logic              capture_s;

  logic [DATA_W-1:0] alu_out_r;
  logic              zero_r;
  logic              lt_r;
  logic              ovf_check_r;
  logic              alu_overflow_r;
  logic              wb_en_r;
  logic [2:0]        wb_sel_r;
  logic [1:0]        reg_dst_r;
  logic [ADDR_W-1:0] rt_r;
  logic [ADDR_W-1:0] rd_r;
  logic [15:0]       imm16_r;

  logic [2:0]        sel_src_s;
  logic [1:0]        dst_src_s;
  logic [ADDR_W-1:0] rt_src_s;
  logic [ADDR_W-1:0] rd_src_s;
  logic [DATA_W-1:0] alu_src_s;
  logic [15:0]       imm_src_s;
  logic              slt_src_s;
  logic              trap_src_s;
  logic              wen_src_s;
  logic              do_write_s;

  logic [DATA_W-1:0] mux_wdata_s;
  logic [ADDR_W-1:0] mux_waddr_s;

  logic              rf_we_s, rf_we_r;
  logic [ADDR_W-1:0] rf_waddr_s, rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_s, rf_wdata_r;
  logic              exc_req_s, exc_req_r;
  logic [1:0]        exc_cause_s, exc_cause_r;
  logic              busy_s, busy_r;

  assign capture_s = (state_r == ST_IDLE) && bus.alu_valid;

`ifdef WB_FAST_EN
  // The decision is made on the capture edge, so it must see the live operands
  assign sel_src_s  = bus.wb_sel;
  assign dst_src_s  = bus.reg_dst;
  assign rt_src_s   = bus.rt;
  assign rd_src_s   = bus.rd;
  assign alu_src_s  = bus.alu_result;
  assign imm_src_s  = bus.imm16;
  assign slt_src_s  = bus.alu_result[DATA_W-1] ^ bus.alu_overflow;
  assign trap_src_s = bus.ovf_check & bus.alu_overflow;
  assign wen_src_s  = bus.wb_en;
`else
  assign sel_src_s  = wb_sel_r;
  assign dst_src_s  = reg_dst_r;
  assign rt_src_s   = rt_r;
  assign rd_src_s   = rd_r;
  assign alu_src_s  = alu_out_r;
  assign imm_src_s  = imm16_r;
  assign slt_src_s  = lt_r;
  assign trap_src_s = ovf_check_r & alu_overflow_r;
  assign wen_src_s  = wb_en_r;
`endif

  assign do_write_s = wen_src_s && (mux_waddr_s != {ADDR_W{1'b0}});

  wb_data_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mux (
    .wb_sel    (sel_src_s),
    .reg_dst   (dst_src_s),
    .rt        (rt_src_s),
    .rd        (rd_src_s),
    .alu_out   (alu_src_s),
    .mdr       (bus.mdr),
    .hi        (bus.hi),
    .lo        (bus.lo),
    .shift_out (bus.shift_out),
    .pc        (bus.pc),
    .imm16     (imm_src_s),
    .slt_bit   (slt_src_s),
    .wdata     (mux_wdata_s),
    .waddr     (mux_waddr_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; overflow trap wins over the write, $0 writes fall to IDLE
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (bus.alu_valid) begin
`ifdef WB_FAST_EN
          if (trap_src_s)      state_next_s = ST_EXC;
          else if (do_write_s) state_next_s = ST_WRITE;
          else                 state_next_s = ST_IDLE;
`else
          state_next_s = ST_CHECK;
`endif
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (trap_src_s)      state_next_s = ST_EXC;
        else if (do_write_s) state_next_s = ST_WRITE;
        else                 state_next_s = ST_IDLE;
      end
      ST_WRITE: state_next_s = ST_IDLE;
      ST_EXC:   state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Output decode for the coming state; registered below so outputs are glitch-free
  always_comb begin
    rf_we_s     = 1'b0;
    rf_waddr_s  = {ADDR_W{1'b0}};
    rf_wdata_s  = {DATA_W{1'b0}};
    exc_req_s   = 1'b0;
    exc_cause_s = EXC_NONE;
    busy_s      = (state_next_s != ST_IDLE);
    case (state_next_s)
      ST_WRITE: begin
        rf_we_s    = 1'b1;
        rf_waddr_s = mux_waddr_s;
        rf_wdata_s = mux_wdata_s;
      end
      ST_EXC: begin
        exc_req_s   = 1'b1;
        exc_cause_s = EXC_OVF;
      end
      default: begin
        rf_we_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_r     <= 1'b0;
      rf_waddr_r  <= {ADDR_W{1'b0}};
      rf_wdata_r  <= {DATA_W{1'b0}};
      exc_req_r   <= 1'b0;
      exc_cause_r <= EXC_NONE;
      busy_r      <= 1'b0;
    end else begin
      rf_we_r     <= rf_we_s;
      rf_waddr_r  <= rf_waddr_s;
      rf_wdata_r  <= rf_wdata_s;
      exc_req_r   <= exc_req_s;
      exc_cause_r <= exc_cause_s;
      busy_r      <= busy_s;
    end
  end

  // Operand capture; ALUOut and flags hold until the next accepted op
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_out_r      <= {DATA_W{1'b0}};
      zero_r         <= 1'b0;
      lt_r           <= 1'b0;
      ovf_check_r    <= 1'b0;
      alu_overflow_r <= 1'b0;
      wb_en_r        <= 1'b0;
      wb_sel_r       <= WB_ALU;
      reg_dst_r      <= DST_RT;
      rt_r           <= {ADDR_W{1'b0}};
      rd_r           <= {ADDR_W{1'b0}};
      imm16_r        <= 16'h0000;
    end else if (capture_s) begin
      alu_out_r      <= bus.alu_result;
      zero_r         <= (bus.alu_result == {DATA_W{1'b0}});
      lt_r           <= bus.alu_result[DATA_W-1] ^ bus.alu_overflow;
      ovf_check_r    <= bus.ovf_check;
      alu_overflow_r <= bus.alu_overflow;
      wb_en_r        <= bus.wb_en;
      wb_sel_r       <= bus.wb_sel;
      reg_dst_r      <= bus.reg_dst;
      rt_r           <= bus.rt;
      rd_r           <= bus.rd;
      imm16_r        <= bus.imm16;
    end
  end

  assign bus.alu_out_reg = alu_out_r;
  assign bus.zero_flag   = zero_r;
  assign bus.lt_flag     = lt_r;
  assign bus.rf_we       = rf_we_r;
  assign bus.rf_waddr    = rf_waddr_r;
  assign bus.rf_wdata    = rf_wdata_r;
  assign bus.exc_req     = exc_req_r;
  assign bus.exc_cause   = exc_cause_r;
  assign bus.busy        = busy_r;

endmodule
